// File: rtl/rgb2raw_bayer.sv
// rgb2raw_bayer: re-mosaics a 24-bit RGB pixel stream into a 10-bit Bayer RAW
// stream with the VS/HS framing delayed to stay aligned (2-cycle latency).
// Optional feature macro: RGB2RAW_DITHER_EN -- when defined, the two LSBs of
// each expanded sample come from a 16-bit LFSR instead of bit replication.

module rgb2raw_bayer #(
    parameter logic [1:0]  BAYER_PHASE = 2'b00,
    parameter logic [10:0] X_MAX       = 11'd2047,
    parameter logic [10:0] Y_MAX       = 11'd2047
) (
    input  logic        VGA_CLK,
    input  logic        RST,
    input  logic        VGA_VS,
    input  logic        VGA_HS,
    input  logic        READ_Request,
    input  logic [7:0]  iRed,
    input  logic [7:0]  iGreen,
    input  logic [7:0]  iBlue,
    output logic [9:0]  oDATA,
    output logic        oDVAL,
    output logic        oVS,
    output logic        oHS,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont
);

    // Frame position counters
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        line_seen_q, line_seen_d;
    logic        vs_fall, hs_fall;
    logic [10:0] x_cur, y_cur;

    // Stage 1 registers (the registered syncs double as the edge-detect history)
    logic [7:0]  s1_red_q, s1_red_d;
    logic [7:0]  s1_green_q, s1_green_d;
    logic [7:0]  s1_blue_q, s1_blue_d;
    logic [1:0]  s1_phase_q, s1_phase_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_vs_q, s1_vs_d;
    logic        s1_hs_q, s1_hs_d;
    logic [10:0] s1_x_q, s1_x_d;
    logic [10:0] s1_y_q, s1_y_d;

    // Stage 2 (output) registers
    logic [7:0]  chan;
    logic [9:0]  expanded;
    logic [9:0]  data_q, data_d;
    logic        dval_q, dval_d;
    logic        vs_q, vs_d;
    logic        hs_q, hs_d;
    logic [10:0] xo_q, xo_d;
    logic [10:0] yo_q, yo_d;

    // Sync edge detection and the coordinates the pixel of this cycle uses
    always_comb begin
        vs_fall = s1_vs_q & ~VGA_VS;
        hs_fall = s1_hs_q & ~VGA_HS;
        x_cur   = hs_fall ? 11'd0 : x_q;
        if (vs_fall) begin
            y_cur = 11'd0;
        end else if (hs_fall && line_seen_q && (y_q != Y_MAX)) begin
            y_cur = y_q + 11'd1;
        end else begin
            y_cur = y_q;
        end
        if (hs_fall) begin
            x_d = 11'd0;
        end else if (READ_Request && (x_q != X_MAX)) begin
            x_d = x_q + 11'd1;
        end else begin
            x_d = x_q;
        end
        y_d         = y_cur;
        line_seen_d = READ_Request | (line_seen_q & ~hs_fall);
    end

    // Stage 1 capture: raw components, CFA site, valid, syncs and coordinates
    always_comb begin
        s1_red_d   = iRed;
        s1_green_d = iGreen;
        s1_blue_d  = iBlue;
        s1_phase_d = {y_cur[0] ^ BAYER_PHASE[1], x_cur[0] ^ BAYER_PHASE[0]};
        s1_valid_d = READ_Request;
        s1_vs_d    = VGA_VS;
        s1_hs_d    = VGA_HS;
        s1_x_d     = x_cur;
        s1_y_d     = y_cur;
    end

`ifdef RGB2RAW_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;

    // Dither LFSR: steps once per pixel leaving stage 1, restarts on each frame
    always_comb begin
        if (vs_fall) begin
            lfsr_d = LFSR_SEED;
        end else if (s1_valid_q) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Dither LFSR state register
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Stage 2: pick the CFA channel, widen it to 10 bits, hold coordinates on gaps
    always_comb begin
        case (s1_phase_q)
            2'b01:   chan = s1_red_q;
            2'b10:   chan = s1_blue_q;
            default: chan = s1_green_q;
        endcase
`ifdef RGB2RAW_DITHER_EN
        if (chan == 8'h00) begin
            expanded = 10'h000;
        end else if (chan == 8'hFF) begin
            expanded = 10'h3FF;
        end else begin
            expanded = {chan, lfsr_q[1:0]};
        end
`else
        expanded = {chan, chan[7:6]};
`endif
        data_d = s1_valid_q ? expanded : 10'd0;
        dval_d = s1_valid_q;
        vs_d   = s1_vs_q;
        hs_d   = s1_hs_q;
        xo_d   = s1_valid_q ? s1_x_q : xo_q;
        yo_d   = s1_valid_q ? s1_y_q : yo_q;
    end

    // Counter and stage 1 registers; syncs reset high so no false edge follows reset
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            x_q         <= 11'd0;
            y_q         <= 11'd0;
            line_seen_q <= 1'b0;
            s1_red_q    <= 8'd0;
            s1_green_q  <= 8'd0;
            s1_blue_q   <= 8'd0;
            s1_phase_q  <= 2'b00;
            s1_valid_q  <= 1'b0;
            s1_vs_q     <= 1'b1;
            s1_hs_q     <= 1'b1;
            s1_x_q      <= 11'd0;
            s1_y_q      <= 11'd0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            line_seen_q <= line_seen_d;
            s1_red_q    <= s1_red_d;
            s1_green_q  <= s1_green_d;
            s1_blue_q   <= s1_blue_d;
            s1_phase_q  <= s1_phase_d;
            s1_valid_q  <= s1_valid_d;
            s1_vs_q     <= s1_vs_d;
            s1_hs_q     <= s1_hs_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            data_q <= 10'd0;
            dval_q <= 1'b0;
            vs_q   <= 1'b1;
            hs_q   <= 1'b1;
            xo_q   <= 11'd0;
            yo_q   <= 11'd0;
        end else begin
            data_q <= data_d;
            dval_q <= dval_d;
            vs_q   <= vs_d;
            hs_q   <= hs_d;
            xo_q   <= xo_d;
            yo_q   <= yo_d;
        end
    end

    assign oDATA   = data_q;
    assign oDVAL   = dval_q;
    assign oVS     = vs_q;
    assign oHS     = hs_q;
    assign oX_Cont = xo_q;
    assign oY_Cont = yo_q;

endmodule

// File: tb/tb_rgb2raw_bayer.sv
// tb_rgb2raw_bayer: randomized and directed checks of rgb2raw_bayer against a
// frame-level reference model. Two instances run side by side (BAYER_PHASE 0
// and 3) on identical stimulus. Define RGB2RAW_DITHER_EN to cover dithering.

module tb_rgb2raw_bayer;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic        dval;
        logic [9:0]  data;
        logic        vs;
        logic        hs;
        logic [10:0] x;
        logic [10:0] y;
    } out_t;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       req;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } stim_t;

    localparam out_t RESET_OUT = out_t'{1'b0, 10'd0, 1'b1, 1'b1, 11'd0, 11'd0};

    logic        VGA_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        VGA_VS = 1'b1;
    logic        VGA_HS = 1'b1;
    logic        READ_Request = 1'b0;
    logic [7:0]  iRed = 8'd0;
    logic [7:0]  iGreen = 8'd0;
    logic [7:0]  iBlue = 8'd0;

    logic [9:0]  d0_data, d3_data;
    logic        d0_dval, d3_dval, d0_vs, d3_vs, d0_hs, d3_hs;
    logic [10:0] d0_x, d3_x, d0_y, d3_y;
    out_t        obs0, obs3;

    int checks = 0;
    int failures = 0;

    // Reference model state: frame-level position bookkeeping
    bit          m_prev_vs, m_prev_hs, m_line_pix;
    int          m_col, m_row;
    logic [10:0] m_lastx, m_lasty;
    logic [15:0] m_lfsr;
    out_t        q0[$];
    out_t        q3[$];
    stim_t       plan[$];

    rgb2raw_bayer #(.BAYER_PHASE(2'b00), .X_MAX(11'd2047), .Y_MAX(11'd2047)) dut (
        .VGA_CLK(VGA_CLK), .RST(RST), .VGA_VS(VGA_VS), .VGA_HS(VGA_HS),
        .READ_Request(READ_Request), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oDATA(d0_data), .oDVAL(d0_dval), .oVS(d0_vs), .oHS(d0_hs),
        .oX_Cont(d0_x), .oY_Cont(d0_y)
    );

    rgb2raw_bayer #(.BAYER_PHASE(2'b11), .X_MAX(11'd2047), .Y_MAX(11'd2047)) dut_p3 (
        .VGA_CLK(VGA_CLK), .RST(RST), .VGA_VS(VGA_VS), .VGA_HS(VGA_HS),
        .READ_Request(READ_Request), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oDATA(d3_data), .oDVAL(d3_dval), .oVS(d3_vs), .oHS(d3_hs),
        .oX_Cont(d3_x), .oY_Cont(d3_y)
    );

    assign obs0 = {d0_dval, d0_data, d0_vs, d0_hs, d0_x, d0_y};
    assign obs3 = {d3_dval, d3_data, d3_vs, d3_hs, d3_x, d3_y};

    always #5 VGA_CLK = ~VGA_CLK;

    function automatic logic [15:0] lfsr_next(logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Bayer site colour from the pixel's column/row parity and the phase
    function automatic logic [7:0] pick(stim_t s, int col, int row, logic [1:0] ph);
        int pr;
        int pc;
        pr = (row % 2) ^ int'(ph[1]);
        pc = (col % 2) ^ int'(ph[0]);
        if (pr == 0 && pc == 1) return s.r;
        if (pr == 1 && pc == 0) return s.b;
        return s.g;
    endfunction

    function automatic logic [9:0] expand(logic [7:0] c);
`ifdef RGB2RAW_DITHER_EN
        if (c == 8'h00) return 10'h000;
        if (c == 8'hFF) return 10'h3FF;
        return 10'(int'(c) * 4 + int'(m_lfsr[1:0]));
`else
        return 10'(int'(c) * 4 + int'(c) / 64);
`endif
    endfunction

    function automatic stim_t mk(bit vs, bit hs, bit req, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        stim_t t;
        t.vs = vs; t.hs = hs; t.req = req; t.r = r; t.g = g; t.b = b;
        return t;
    endfunction

    task automatic model_reset();
        m_prev_vs = 1'b1; m_prev_hs = 1'b1; m_line_pix = 1'b0;
        m_col = 0; m_row = 0; m_lastx = 11'd0; m_lasty = 11'd0; m_lfsr = SEED;
        q0.delete(); q3.delete();
        q0.push_back(RESET_OUT);
        q3.push_back(RESET_OUT);
    endtask

    task automatic plan_sync(bit with_vs);
        plan.push_back(mk(!with_vs, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    endtask

    task automatic plan_idle(int n);
        for (int i = 0; i < n; i++) plan.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
    endtask

    task automatic plan_pix(int n, logic [7:0] r, logic [7:0] g, logic [7:0] b, bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) plan.push_back(mk(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom)));
            else     plan.push_back(mk(1'b1, 1'b1, 1'b1, r, g, b));
        end
    endtask

    // Drive one cycle, update the model, and hand back observed/expected outputs
    task automatic run_step(input stim_t s, output out_t got0, output out_t exp0,
                            output out_t got3, output out_t exp3, output bit have);
        out_t e0, e3;
        bit   hs_fall, vs_fall;
        VGA_VS = s.vs; VGA_HS = s.hs; READ_Request = s.req;
        iRed = s.r; iGreen = s.g; iBlue = s.b;
        hs_fall = m_prev_hs && !s.hs;
        vs_fall = m_prev_vs && !s.vs;
        m_prev_hs = s.hs;
        m_prev_vs = s.vs;
        if (hs_fall) begin
            if (m_line_pix && m_row < 2047) m_row++;
            m_col = 0;
            m_line_pix = 1'b0;
        end
        if (vs_fall) begin
            m_row = 0;
            m_lfsr = SEED;
        end
        e0 = RESET_OUT;
        e0.vs = s.vs; e0.hs = s.hs; e0.dval = s.req;
        e3 = e0;
        if (s.req) begin
            m_lastx = 11'(m_col);
            m_lasty = 11'(m_row);
            e0.data = expand(pick(s, m_col, m_row, 2'b00));
            e3.data = expand(pick(s, m_col, m_row, 2'b11));
            m_lfsr = lfsr_next(m_lfsr);
            m_line_pix = 1'b1;
            if (!hs_fall && m_col < 2047) m_col++;
        end
        e0.x = m_lastx; e0.y = m_lasty;
        e3.x = m_lastx; e3.y = m_lasty;
        q0.push_back(e0);
        q3.push_back(e3);
        @(posedge VGA_CLK);
        #1;
        got0 = obs0;
        got3 = obs3;
        exp0 = RESET_OUT;
        exp3 = RESET_OUT;
        have = 1'b0;
        if (q0.size() >= 2) begin
            exp0 = q0.pop_front();
            exp3 = q3.pop_front();
            have = 1'b1;
        end
    endtask

    task automatic test_reset();
        out_t g0, e0, g3, e3;
        bit   have;
        RST = 1'b1;
        VGA_VS = 1'b1; VGA_HS = 1'b1; READ_Request = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge VGA_CLK);
            #1;
            checks++;
            if (obs0 !== RESET_OUT || obs3 !== RESET_OUT) begin
                failures++;
                $display("[TB] FAIL reset_hold cycle %0d: got p0=%h p3=%h expected %h", i, obs0, obs3, RESET_OUT);
            end
        end
        RST = 1'b0;
        run_step(mk(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0), g0, e0, g3, e3, have);
        checks++;
        if (g0 !== RESET_OUT || g3 !== RESET_OUT) begin
            failures++;
            $display("[TB] FAIL reset_release: got p0=%h p3=%h expected %h", g0, g3, RESET_OUT);
        end
    endtask

    task automatic build_frame42();
        plan.delete();
        plan_sync(1'b1);
        plan_pix(4, 8'h40, 8'h80, 8'hC0, 1'b0);
        plan_sync(1'b0);
        plan_pix(4, 8'h40, 8'h80, 8'hC0, 1'b0);
        plan_idle(3);
    endtask

    task automatic test_mosaic();
        out_t       g0, e0, g3, e3;
        bit         have;
        int         nval;
        logic [9:0] want [8];
        logic [9:0] seen [8];
        want = '{10'h202, 10'h101, 10'h202, 10'h101, 10'h303, 10'h202, 10'h303, 10'h202};
        seen = '{default: 10'h0};
        build_frame42();
        nval = 0;
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL mosaic step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
            if (g0.dval === 1'b1) begin
                if (nval < 8) seen[nval] = g0.data;
                nval++;
            end
        end
        checks++;
        if (nval != 8) begin
            failures++;
            $display("[TB] FAIL mosaic_dval_count: got %0d expected 8", nval);
        end
`ifndef RGB2RAW_DITHER_EN
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seen[k] !== want[k]) begin
                failures++;
                $display("[TB] FAIL mosaic_p0 sample %0d: got %h expected %h", k, seen[k], want[k]);
            end
        end
`endif
    endtask

    task automatic test_phase();
        out_t       g0, e0, g3, e3;
        bit         have;
        int         nval;
        logic [9:0] want [8];
        logic [9:0] seen [8];
        want = '{10'h202, 10'h303, 10'h202, 10'h303, 10'h101, 10'h202, 10'h101, 10'h202};
        seen = '{default: 10'h0};
        build_frame42();
        nval = 0;
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL phase step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
            if (g3.dval === 1'b1) begin
                if (nval < 8) seen[nval] = g3.data;
                nval++;
            end
        end
        checks++;
        if (nval != 8) begin
            failures++;
            $display("[TB] FAIL phase_dval_count: got %0d expected 8", nval);
        end
`ifndef RGB2RAW_DITHER_EN
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seen[k] !== want[k]) begin
                failures++;
                $display("[TB] FAIL phase_p3 sample %0d: got %h expected %h", k, seen[k], want[k]);
            end
        end
`endif
    endtask

    task automatic test_framing();
        out_t g0, e0, g3, e3;
        bit   have;
        out_t vals[$];
        plan.delete();
        plan_sync(1'b1);
        plan_pix(2, 8'd0, 8'd0, 8'd0, 1'b1);
        plan_sync(1'b0);
        plan_idle(2);
        plan_sync(1'b0);
        plan_pix(1, 8'd0, 8'd0, 8'd0, 1'b1);
        plan_idle(2);
        plan_sync(1'b1);
        plan_pix(1, 8'd0, 8'd0, 8'd0, 1'b1);
        plan_idle(1);
        plan.push_back(mk(1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33));
        plan_idle(3);
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL framing step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
            if (g0.dval === 1'b1) vals.push_back(g0);
        end
        checks++;
        if (vals.size() != 5) begin
            failures++;
            $display("[TB] FAIL framing_count: got %0d expected 5", vals.size());
        end else begin
            checks += 3;
            if (vals[2].y !== 11'd1) begin
                failures++;
                $display("[TB] FAIL empty_line_y: got %0d expected 1", vals[2].y);
            end
            if (vals[3].y !== 11'd0) begin
                failures++;
                $display("[TB] FAIL vs_hs_together_y: got %0d expected 0", vals[3].y);
            end
            if (vals[4].x !== 11'd0) begin
                failures++;
                $display("[TB] FAIL hs_with_pixel_x: got %0d expected 0", vals[4].x);
            end
        end
    endtask

    task automatic test_saturation();
        out_t g0, e0, g3, e3;
        bit   have;
        int   nsat;
        logic [10:0] lastx;
        plan.delete();
        plan_sync(1'b0);
        plan_pix(2050, 8'd0, 8'd0, 8'd0, 1'b1);
        plan_idle(3);
        nsat = 0;
        lastx = 11'd0;
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL saturate step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
            if (g0.dval === 1'b1) begin
                lastx = g0.x;
                if (g0.x === 11'd2047) nsat++;
            end
        end
        checks += 2;
        if (lastx !== 11'd2047) begin
            failures++;
            $display("[TB] FAIL x_saturate_last: got %0d expected 2047", lastx);
        end
        if (nsat != 3) begin
            failures++;
            $display("[TB] FAIL x_saturate_count: got %0d expected 3", nsat);
        end
    endtask

    task automatic test_midreset();
        out_t g0, e0, g3, e3;
        bit   have;
        int   first;
        plan.delete();
        plan_sync(1'b1);
        for (int r = 0; r < 4; r++) begin
            if (r > 0) plan_sync(1'b0);
            plan_pix((r == 3) ? 5 : 8, 8'd0, 8'd0, 8'd0, 1'b1);
        end
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL midreset_pre step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
        end
        RST = 1'b1;
        VGA_VS = 1'b1; VGA_HS = 1'b1; READ_Request = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs0 !== RESET_OUT || obs3 !== RESET_OUT) begin
            failures++;
            $display("[TB] FAIL midreset_async: got p0=%h p3=%h expected %h", obs0, obs3, RESET_OUT);
        end
        @(posedge VGA_CLK);
        #1;
        RST = 1'b0;
        plan.delete();
        plan_pix(3, 8'd0, 8'd0, 8'd0, 1'b1);
        plan_idle(3);
        first = -1;
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL midreset_post step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
            if (g0.dval === 1'b1 && first < 0) begin
                first = i;
                checks++;
                if (g0.x !== 11'd0 || g0.y !== 11'd0) begin
                    failures++;
                    $display("[TB] FAIL midreset_first_xy: got (%0d,%0d) expected (0,0)", g0.x, g0.y);
                end
            end
        end
        checks++;
        if (first != 1) begin
            failures++;
            $display("[TB] FAIL midreset_flush: first valid at step %0d expected 1", first);
        end
    endtask

    task automatic test_random();
        out_t g0, e0, g3, e3;
        bit   have;
        int   rows;
        plan.delete();
        for (int f = 0; f < 3; f++) begin
            plan_sync(1'b1);
            rows = int'($urandom_range(2, 5));
            for (int r = 0; r < rows; r++) begin
                if (r > 0) plan_sync(1'b0);
                if ($urandom_range(0, 4) != 0) begin
                    for (int p = 0; p < int'($urandom_range(1, 12)); p++) begin
                        plan_pix(1, 8'd0, 8'd0, 8'd0, 1'b1);
                        if ($urandom_range(0, 3) == 0) plan_idle(int'($urandom_range(1, 3)));
                    end
                end
                plan_idle(int'($urandom_range(0, 3)));
            end
        end
        plan_idle(3);
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL random step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
        end
    endtask

`ifdef RGB2RAW_DITHER_EN
    task automatic test_dither();
        out_t        g0, e0, g3, e3;
        bit          have;
        logic [9:0]  vals[$];
        logic [15:0] l;
        logic [9:0]  want;
        plan.delete();
        plan_sync(1'b1);
        plan_pix(16, 8'h80, 8'h80, 8'h80, 1'b0);
        plan_pix(1, 8'h00, 8'h00, 8'h00, 1'b0);
        plan_pix(1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        plan_idle(2);
        plan_sync(1'b1);
        plan_pix(16, 8'h80, 8'h80, 8'h80, 1'b0);
        plan_idle(3);
        foreach (plan[i]) begin
            run_step(plan[i], g0, e0, g3, e3, have);
            if (have) begin
                checks++;
                if ({g0, g3} !== {e0, e3}) begin
                    failures++;
                    $display("[TB] FAIL dither step %0d: got p0=%h p3=%h expected p0=%h p3=%h", i, g0, g3, e0, e3);
                end
            end
            if (g0.dval === 1'b1) vals.push_back(g0.data);
        end
        checks++;
        if (vals.size() != 34) begin
            failures++;
            $display("[TB] FAIL dither_count: got %0d expected 34", vals.size());
        end else begin
            l = SEED;
            for (int k = 0; k < 16; k++) begin
                want = {8'h80, l[1:0]};
                checks += 2;
                if (vals[k] !== want) begin
                    failures++;
                    $display("[TB] FAIL dither_seq %0d: got %h expected %h", k, vals[k], want);
                end
                if (vals[18 + k] !== want) begin
                    failures++;
                    $display("[TB] FAIL dither_restart %0d: got %h expected %h", k, vals[18 + k], want);
                end
                l = lfsr_next(l);
            end
            checks += 2;
            if (vals[16] !== 10'h000) begin
                failures++;
                $display("[TB] FAIL dither_zero: got %h expected 000", vals[16]);
            end
            if (vals[17] !== 10'h3FF) begin
                failures++;
                $display("[TB] FAIL dither_full: got %h expected 3ff", vals[17]);
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] starting rgb2raw_bayer bench");
        test_reset();
        test_mosaic();
        test_phase();
        test_framing();
        test_saturation();
        test_midreset();
        test_random();
`ifdef RGB2RAW_DITHER_EN
        test_dither();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
